// File: rtl/cmos_pixel_packer.sv
// DVP camera byte-stream to pixel packer: frame-locked capture, pixel/line
// counters, line/frame measurement, RGB565->RGB888 expansion, partial-pixel flag.
module cmos_pixel_packer #(
    parameter int DATA_W        = 8,
    parameter int BEATS_PER_PIX = 2,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int X_W           = 12,
    parameter int Y_W           = 12
) (
    input  logic                            i_pclk,
    input  logic                            i_rst,
    input  logic                            i_enable,
    input  logic                            i_vsync,
    input  logic                            i_href,
    input  logic [DATA_W-1:0]               i_pdata,
    input  logic                            i_err_clr,
    output logic [DATA_W*BEATS_PER_PIX-1:0] o_pix_data,
    output logic [23:0]                     o_rgb888,
    output logic                            o_pix_valid,
    output logic                            o_sof,
    output logic                            o_eol,
    output logic [X_W-1:0]                  o_x,
    output logic [Y_W-1:0]                  o_y,
    output logic [X_W-1:0]                  o_line_len,
    output logic [Y_W-1:0]                  o_frame_lines,
    output logic                            o_locked,
    output logic                            o_err_partial
);
    localparam int         PIX_W = DATA_W * BEATS_PER_PIX;
    localparam logic [1:0] LAST  = 2'(BEATS_PER_PIX - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
    state_t r_state;

    logic [BEATS_PER_PIX-1:0][DATA_W-1:0] r_slot;
    logic [1:0]     r_phase;
    logic           r_vs_d, r_href_d, r_sof_arm;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;

    logic             w_vs, w_vs_start, w_href_fall, w_err_set;
    logic [X_W-1:0]   w_x_inc;
    logic [Y_W-1:0]   w_y_inc;
    logic [PIX_W-1:0] w_pix;
    logic [23:0]      w_rgb;

    assign w_vs        = (i_vsync == VS_POL);
    assign w_vs_start  = w_vs & ~r_vs_d;
    assign w_href_fall = r_href_d & ~i_href;
    assign w_err_set   = (r_state == ACTIVE) && w_href_fall && (r_phase != 2'd0);
    assign w_x_inc     = (&r_x) ? r_x : r_x + 1'b1;
    assign w_y_inc     = (&r_y) ? r_y : r_y + 1'b1;

    // The beat being sampled now bypasses the slot registers so the pixel
    // can be registered on the same edge as its last beat.
    for (genvar k = 0; k < BEATS_PER_PIX; k++) begin : g_slot
        localparam int POS = MSB_FIRST ? (BEATS_PER_PIX - 1 - k) : k;
        assign w_pix[POS*DATA_W +: DATA_W] = (r_phase == 2'(k)) ? i_pdata : r_slot[k];
    end

    if (PIX_W == 16) begin : g_rgb
        assign w_rgb = {w_pix[15:11], w_pix[15:13], w_pix[10:5], w_pix[10:9],
                        w_pix[4:0], w_pix[4:2]};
    end else begin : g_norgb
        assign w_rgb = '0;
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_slot        <= '0;
            r_phase       <= '0;
            r_vs_d        <= 1'b0;
            r_href_d      <= 1'b0;
            r_sof_arm     <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            o_pix_data    <= '0;
            o_rgb888      <= '0;
            o_pix_valid   <= 1'b0;
            o_sof         <= 1'b0;
            o_eol         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
            o_locked      <= 1'b0;
            o_err_partial <= 1'b0;
        end else begin
            r_vs_d        <= w_vs;
            r_href_d      <= i_href;
            o_pix_valid   <= 1'b0;
            o_sof         <= 1'b0;
            o_eol         <= 1'b0;
            o_err_partial <= w_err_set | (o_err_partial & ~i_err_clr);
            case (r_state)
                IDLE: if (i_enable) r_state <= WAIT_VS;
                WAIT_VS: if (w_vs_start) begin
                    r_state   <= ACTIVE;
                    o_locked  <= 1'b1;
                    r_x       <= '0;
                    r_y       <= '0;
                    r_phase   <= '0;
                    r_sof_arm <= 1'b1;
                end
                ACTIVE: begin
                    if (i_href) begin
                        for (int k = 0; k < BEATS_PER_PIX; k++)
                            if (r_phase == 2'(k)) r_slot[k] <= i_pdata;
                        if (r_phase == LAST) begin
                            r_phase     <= '0;
                            o_pix_valid <= 1'b1;
                            o_pix_data  <= w_pix;
                            o_rgb888    <= w_rgb;
                            o_x         <= r_x;
                            o_y         <= r_y;
                            o_sof       <= r_sof_arm;
                            r_x         <= w_x_inc;
                            r_sof_arm   <= 1'b0;
                        end else begin
                            r_phase <= r_phase + 2'd1;
                        end
                    end
                    if (w_href_fall) begin
                        o_eol      <= 1'b1;
                        o_line_len <= r_x;
                        r_x        <= '0;
                        r_y        <= w_y_inc;
                        r_phase    <= '0;
                    end
                    // A line closing on the same edge is counted into this frame.
                    if (w_vs_start) begin
                        o_frame_lines <= w_href_fall ? w_y_inc : r_y;
                        r_y           <= '0;
                        r_sof_arm     <= 1'b1;
                        if (!i_enable) begin
                            r_state  <= IDLE;
                            o_locked <= 1'b0;
                            r_phase  <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
